// File: rtl/serial_transceiver_pkg.sv
// Shared types and constants for the 8N1 serial echo block.
package serial_transceiver_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: start detection with false-start rejection, mid-bit sampling, stop-bit check.
// SERIAL_TRANSCEIVER_RX_SYNC_EN inserts a 2-flop synchronizer on the serial input.
module uart_rx
    import serial_transceiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_t             r_state;
    rx_state_t             w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [BIT_W-1:0]      r_bit;
    logic [BIT_W-1:0]      w_bit_next;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_next;
    logic                  r_valid;
    logic                  w_valid_next;
    logic                  w_rx;

`ifdef SERIAL_TRANSCEIVER_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {2{IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = i_rx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_valid <= w_valid_next;
        end
    end

    // The counter restarts at every bit boundary, so it only ever spans one bit period.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_valid_next = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_next = '0;
                if (w_rx == START_LEVEL) begin
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = (w_rx == START_LEVEL) ? RX_DATA : RX_IDLE;
                end
            end
            RX_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx, r_shift[DATA_BITS-1:1]};
                    if (r_bit == LAST_BIT) begin
                        w_state_next = RX_STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_next = '0;
                    if (w_rx == IDLE_LEVEL) begin
                        w_valid_next = 1'b1;
                        w_state_next = RX_IDLE;
                    end else begin
                        w_state_next = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                w_cnt_next = '0;
                if (w_rx == IDLE_LEVEL) begin
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = RX_IDLE;
            end
        endcase
    end

    assign o_valid = r_valid;
    assign o_data  = r_shift;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter with a registered line output; takes a byte whenever idle and one is offered.
module uart_tx
    import serial_transceiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_load,
    output logic                 o_tx
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [BIT_W-1:0]      r_bit;
    logic [BIT_W-1:0]      w_bit_next;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_next;
    logic                  r_tx;
    logic                  w_tx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= IDLE_LEVEL;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    // The line level is computed alongside the state so it changes on the same edge as the state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        o_load       = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_cnt_next = '0;
                w_tx_next  = IDLE_LEVEL;
                if (i_valid) begin
                    o_load       = 1'b1;
                    w_shift_next = i_data;
                    w_bit_next   = '0;
                    w_state_next = TX_START;
                    w_tx_next    = START_LEVEL;
                end
            end
            TX_START: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_next   = '0;
                    w_state_next = TX_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            TX_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_next = '0;
                    if (r_bit == LAST_BIT) begin
                        w_state_next = TX_STOP;
                        w_tx_next    = IDLE_LEVEL;
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_next    = r_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_next   = '0;
                    w_state_next = TX_IDLE;
                    w_tx_next    = IDLE_LEVEL;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = TX_IDLE;
                w_tx_next    = IDLE_LEVEL;
            end
        endcase
    end

    assign o_tx = r_tx;

endmodule

// File: rtl/serial_transceiver.sv
// UART 8N1 echo: every correctly framed byte received on din is retransmitted on dout.
// Define SERIAL_TRANSCEIVER_RX_SYNC_EN to add a 2-flop synchronizer on din (+2 clk latency).
module serial_transceiver
    import serial_transceiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic                  w_rx_valid;
    logic [DATA_BITS-1:0]  w_rx_data;
    logic                  w_tx_load;
    logic                  r_hold_valid;
    logic [DATA_BITS-1:0]  r_hold;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF_BIT     (HALF_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .i_rx    (din),
        .o_valid (w_rx_valid),
        .o_data  (w_rx_data)
    );

    // Single-entry holding register: a newly received byte wins over both a stale byte and a TX take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_rx_valid) begin
            r_hold       <= w_rx_data;
            r_hold_valid <= 1'b1;
        end else if (w_tx_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_hold_valid),
        .i_data  (r_hold),
        .o_load  (w_tx_load),
        .o_tx    (dout)
    );

endmodule

// File: tb/tb_serial_transceiver.sv
// Scoreboard bench for serial_transceiver: frames are queued as they are sent on din,
// and an independent monitor decodes dout and checks each echoed frame against the queue.
module tb_serial_transceiver;
    import serial_transceiver_pkg::*;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef SERIAL_TRANSCEIVER_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // din fall -> first detecting edge (1) -> start sample (HALF) -> stop sample (9 bits) -> dout fall (2)
    localparam int NOM_LAT = 1 + HALF + 9 * CPB + 2 + SYNC_LAT;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic dout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] expByteQ[$];
    int         expCycQ[$];
    logic monEnable = 1'b1;
    logic monBusy   = 1'b0;

    serial_transceiver #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HALF)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, data, START_LEVEL};
        for (int i = 0; i < 10; i++) begin
            din = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; only a frame with a good stop bit is expected back on dout.
    task automatic applyStimulus(input logic [7:0] data, input logic stopOk, input int gap);
        if (stopOk) begin
            expByteQ.push_back(data);
            expCycQ.push_back(cyc);
        end
        sendFrame(data, stopOk);
        if (!stopOk) begin
            repeat (CPB) @(posedge clk);
            #1;
        end
        din = 1'b1;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic sendGlitch(input int len);
        din = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        din = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string name, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (dout !== 1'b1) bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    task automatic waitDrain();
        int budget = 40 * CPB;
        while ((expByteQ.size() != 0 || monBusy) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        checkOutput("scoreboard drained", expByteQ.size() + int'(monBusy), 0);
    endtask

    // Monitor: decode each dout frame at mid-bit and compare with the oldest expected byte.
    initial begin : monitor
        logic       prevDout;
        logic [9:0] got;
        logic [7:0] expB;
        int         expC;
        int         fallCyc;
        int         lat;
        prevDout = 1'b1;
        forever begin
            @(negedge clk);
            if (monEnable && prevDout === 1'b1 && dout === 1'b0) begin
                monBusy = 1'b1;
                fallCyc = cyc;
                repeat (HALF) @(negedge clk);
                got[0] = dout;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = dout;
                end
                if (expByteQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected dout frame: got byte 0x%02h expected no frame", got[8:1]);
                end else begin
                    expB = expByteQ.pop_front();
                    expC = expCycQ.pop_front();
                    lat  = fallCyc - expC;
                    checkOutput("start bit", int'(got[0]), 0);
                    checkOutput("stop bit", int'(got[9]), 1);
                    checkOutput("echo byte", int'(got[8:1]), int'(expB));
                    checks++;
                    if (lat < NOM_LAT || lat > NOM_LAT + 2) begin
                        errors++;
                        $display("[TB] FAIL latency: got %0d expected %0d..%0d", lat, NOM_LAT, NOM_LAT + 2);
                    end
                end
                prevDout = dout;
                monBusy  = 1'b0;
            end else begin
                prevDout = dout;
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       ok;
        int         budget;
        rst = 1'b1;
        din = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset dout", int'(dout), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkIdle("idle after reset", 300);
        @(posedge clk);
        #1;

        applyStimulus(8'h63, 1'b1, 2 * CPB);
        waitDrain();
        applyStimulus(8'h8E, 1'b1, 3 * CPB);
        waitDrain();

        sendGlitch(HALF / 2);
        checkIdle("false start rejected", 12 * CPB);
        @(posedge clk);
        #1;

        fork
            applyStimulus(8'h55, 1'b0, 2 * CPB);
            checkIdle("framing error silent", 14 * CPB);
        join
        @(posedge clk);
        #1;
        applyStimulus(8'hA5, 1'b1, CPB);
        waitDrain();

        applyStimulus(8'h00, 1'b1, 0);
        applyStimulus(8'hFF, 1'b1, CPB);
        waitDrain();

        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4) == 0) sendGlitch(int'($urandom_range(1, HALF - 2)));
            applyStimulus(b, ok, int'($urandom_range(1, 3 * CPB)));
        end
        waitDrain();

        // Reset while a frame is on dout: line must go idle at once and stay idle.
        monEnable = 1'b0;
        sendFrame(8'h00, 1'b1);
        din = 1'b1;
        budget = 20 * CPB;
        while (dout !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("mid-tx frame started", int'(dout), 0);
        repeat (3 * CPB) @(negedge clk);
        checkOutput("dout low before reset", int'(dout), 0);
        rst = 1'b1;
        #1;
        checkOutput("dout high on reset", int'(dout), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("no bits after reset", 12 * CPB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_transceiver.md
Name: serial_transceiver

Overview:
- UART 8N1 echo block: receives serial frames on din and retransmits each correctly framed byte unchanged on dout.
- Default timing targets 9600 baud from a 50 MHz clk (5208 clk per bit).
- Sits between an external serial line and its return line; no parallel interface.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit for RX and TX; legal range is 4 or more.
- HALF_BIT, CLKS_PER_BIT/2 (2604), derived offset from the start-bit falling edge to the start-bit sample point.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial receive line; idle level is 1.
- dout  output  1  serial transmit line; idle level is 1.

Behaviour:
- Reset (async, active-high):
  - dout=1.
  - RX and TX FSMs go to IDLE.
  - Counters, shift registers and the holding register are cleared; the holding-valid flag is 0.
- Reset mid-frame aborts any RX or TX frame, and dout goes to 1 immediately.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: wait for din==0, then go to START and clear the counter.
  - START: after HALF_BIT clk, sample din.
    - din==0: go to DATA.
    - din==1: false start; return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT clk, at mid-bit. Shift samples into an 8-bit register LSB first. After the 8th sample go to STOP.
  - STOP: sample din after CLKS_PER_BIT clk.
    - din==1: byte valid; write it to the holding register and set holding-valid; go to IDLE.
    - din==0: framing error; discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: stay until din==1, then go to IDLE.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: dout=1. When holding-valid==1, load the byte into the TX shift register, clear holding-valid, go to START.
  - START: dout=0 for CLKS_PER_BIT clk.
  - DATA: 8 bits LSB first, CLKS_PER_BIT clk each.
  - STOP: dout=1 for CLKS_PER_BIT clk, then return to IDLE.
  - Back-to-back bytes have no extra idle gap beyond the one IDLE cycle.
- Latency: the dout start-bit falling edge occurs 2 clk after the RX stop-bit sample point. That is about 9.5*CLKS_PER_BIT+HALF_BIT-relative+2 clk after the din start edge: roughly 9.5 bit times plus 2 clk.
- Holding register is single-entry. If RX delivers a byte while holding-valid==1, the new byte overwrites the old one (the old byte is lost).
- RX and TX run independently. RX keeps receiving while TX is busy.
- dout is registered, so it is glitch-free.
- Counter width is $clog2(CLKS_PER_BIT). Each counter resets to 0 at every bit boundary.

Optional Feature:
- Macro SERIAL_TRANSCEIVER_RX_SYNC_EN.
- Defined: din passes through a 2-flop synchronizer (both flops reset to 1) before the RX FSM. This adds exactly 2 clk to RX and end-to-end latency.
- Undefined: the RX FSM samples din directly. The bench must then keep din synchronous to clk.

Decomposition:
- Shared package serial_transceiver_pkg holds:
  - the RX and TX state enum typedefs;
  - the constants DATA_BITS=8, IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- Natural sub-modules: uart_rx (FSM, sampler, optional synchronizer) and uart_tx (FSM, shift register).
- Top level serial_transceiver instantiates both and owns the holding register.

Test Plan:
- Idle: din=1 for 5000 clk after reset → dout stays 1 throughout.
- Byte 0x63: din=0, then 1,1,0,0,0,1,1,0, then 1, each bit 5208 clk → dout emits 0,1,1,0,0,0,1,1,0,1 at 5208 clk per bit, starting about 49476 clk after the din fall.
- Byte 0x8E sent about 200000 clk after the first frame: bits 0,0,1,1,1,0,0,0,1,1 → dout emits start 0, data 0,1,1,1,0,0,0,1, stop 1.
- Glitch: din=0 for 1000 clk, then back to 1 → false start rejected; dout stays 1.
- Framing error: frame 0x55 with stop bit 0, then din=1 → no dout activity. A following valid 0xA5 frame echoes correctly.
- Back-to-back 0x00 then 0xFF with minimal gap → both echoed in order. rst asserted mid-TX → dout=1 on the same edge and no further bits.
